exu_alu_arb: RTL

Two-requester issue arbiter in front of the single shared `exu_alu` instance. It buffers one ALU operation per requester: dispatch lane 0 and dispatch lane 1. Each cycle it grants one buffered operation to the ALU, round-robin by default and oldest-first when configured. It holds the presented operation stable while the ALU reports a writeback stall, and drops all pending work on an interrupt flush.

---
 rtl/exu_alu_arb_pkg.sv | 39 +++
 rtl/exu_alu_arb_slot.sv | 58 +++++
 rtl/gnrl_dfflr.sv | 26 ++
 rtl/exu_alu_arb.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/exu_alu_arb_pkg.sv
// Purpose : shared types and helpers for the two-lane ALU issue arbiter.
// Latency : n/a (package only).
// Backpr. : n/a. Defaults for ALU_OP_WIDTH / COMMIT_ID_WIDTH apply when the core does not define them.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 8
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 3
`endif

package exu_alu_arb_pkg;

    localparam int ARB_DW    = 32;
    localparam int ARB_OPW   = `ALU_OP_WIDTH;
    localparam int ARB_CIDW  = `COMMIT_ID_WIDTH;
    localparam int NUM_LANES = 2;

    typedef struct packed {
        logic [ARB_DW-1:0]   op1;
        logic [ARB_DW-1:0]   op2;
        logic [ARB_OPW-1:0]  op_info;
        logic [4:0]          rd;
        logic                reg_we;
        logic [ARB_CIDW-1:0] cid;
    } alu_req_t;

    // Commit IDs wrap, so age is judged on the modular distance: lane 0 is
    // older when cid1 is ahead of cid0 by less than half the ID space.
    // Equal IDs resolve to lane 0.
    function automatic logic age_pick_lane1(input logic [ARB_CIDW-1:0] cid0,
                                            input logic [ARB_CIDW-1:0] cid1);
        logic [ARB_CIDW-1:0] diff;
        logic                lane0_older;
        diff        = cid1 - cid0;
        lane0_older = (diff != '0) && !diff[ARB_CIDW-1];
        return !lane0_older && (diff != '0);
    endfunction

endpackage

// File: rtl/exu_alu_arb_slot.sv
// Purpose : one-entry request buffer for a single dispatch lane (vld + payload).
// Latency : accepted entry is visible on vld_o/req_o the next cycle.
// Backpr. : ready_o low when full and not issuing, or during flush.
// Ports   : valid_i/ready_o/req_i from dispatch, issue_i from arbiter, vld_o/req_o to arbiter.
module exu_alu_arb_slot
    import exu_alu_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush_i,
    input  logic     valid_i,
    input  alu_req_t req_i,
    input  logic     issue_i,
    output logic     ready_o,
    output logic     vld_o,
    output alu_req_t req_o
);

    logic     vld_q;
    logic     vld_d;
    logic     accept;
    alu_req_t req_q;

    // An entry leaving this cycle frees the slot for a same-cycle reload.
    assign ready_o = ~flush_i & (~vld_q | issue_i);
    assign accept  = valid_i & ready_o;

    always_comb begin
        vld_d = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (accept) begin
            vld_d = 1'b1;
        end else if (issue_i) begin
            vld_d = 1'b0;
        end
    end

    gnrl_dfflr #(.DW(1)) u_vld (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (1'b1),
        .dnxt  (vld_d),
        .qout  (vld_q)
    );

    gnrl_dfflr #(.DW($bits(alu_req_t))) u_payload (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (accept),
        .dnxt  (req_i),
        .qout  (req_q)
    );

    assign vld_o = vld_q;
    assign req_o = req_q;

endmodule

// File: rtl/gnrl_dfflr.sv
// Purpose : generic load-enabled register with asynchronous active-low clear.
// Latency : 1 cycle from dnxt to qout when lden is set.
// Backpr. : none; holds value while lden is low.
module gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    logic [DW-1:0] qout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_q <= '0;
        end else if (lden) begin
            qout_q <= dnxt;
        end
    end

    assign qout = qout_q;

endmodule

// File: rtl/exu_alu_arb.sv
// Purpose : two-lane issue arbiter in front of the shared exu_alu; round-robin, or
//           oldest-commit-ID first when ALU_ARB_AGE_PRIO_EN is defined.
// Latency : accept in T, presented to the ALU in T+1 at the earliest.
// Backpr. : alu_stall_i freezes grant/payload; lane ready drops while its buffer is held.
// Ports   : reqN_* dispatch lanes (valid/ready + payload), alu_* presented operation,
//           grant_o one-hot lane, flush_i drops all buffered work.
module exu_alu_arb
    import exu_alu_arb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OPW  = `ALU_OP_WIDTH,
    parameter int CIDW = `COMMIT_ID_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [DW-1:0]   req0_op1_i,
    input  logic [DW-1:0]   req0_op2_i,
    input  logic [OPW-1:0]  req0_op_info_i,
    input  logic [4:0]      req0_rd_i,
    input  logic            req0_reg_we_i,
    input  logic [CIDW-1:0] req0_cid_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [DW-1:0]   req1_op1_i,
    input  logic [DW-1:0]   req1_op2_i,
    input  logic [OPW-1:0]  req1_op_info_i,
    input  logic [4:0]      req1_rd_i,
    input  logic            req1_reg_we_i,
    input  logic [CIDW-1:0] req1_cid_i,
    input  logic            alu_stall_i,
    output logic            req_alu_o,
    output logic [DW-1:0]   alu_op1_o,
    output logic [DW-1:0]   alu_op2_o,
    output logic [OPW-1:0]  alu_op_info_o,
    output logic [4:0]      alu_rd_o,
    output logic            alu_reg_we_o,
    output logic [CIDW-1:0] alu_cid_o,
    output logic [1:0]      grant_o
);

    alu_req_t             req_in  [NUM_LANES];
    alu_req_t             buf_req [NUM_LANES];
    logic [NUM_LANES-1:0] vld;
    logic [NUM_LANES-1:0] ready;
    logic [NUM_LANES-1:0] valid_in;
    logic [NUM_LANES-1:0] issue;
    logic [NUM_LANES-1:0] sel;
    logic [NUM_LANES-1:0] grant;
    alu_req_t             sel_req;

    // A stalled grant is remembered so the choice cannot flip when the other
    // lane fills (or the priority state changes) while the ALU is blocked.
    logic                 hold_q;
    logic                 hold_d;
    logic [NUM_LANES-1:0] hold_gnt_q;
    logic [NUM_LANES-1:0] hold_gnt_d;

    assign req_in[0] = '{op1: req0_op1_i, op2: req0_op2_i, op_info: req0_op_info_i,
                         rd: req0_rd_i, reg_we: req0_reg_we_i, cid: req0_cid_i};
    assign req_in[1] = '{op1: req1_op1_i, op2: req1_op2_i, op_info: req1_op_info_i,
                         rd: req1_rd_i, reg_we: req1_reg_we_i, cid: req1_cid_i};
    assign valid_in  = {req1_valid_i, req0_valid_i};

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_slot
        exu_alu_arb_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush_i),
            .valid_i (valid_in[n]),
            .req_i   (req_in[n]),
            .issue_i (issue[n]),
            .ready_o (ready[n]),
            .vld_o   (vld[n]),
            .req_o   (buf_req[n])
        );
    end

`ifndef ALU_ARB_AGE_PRIO_EN
    logic rr_q;
    logic rr_d;
`endif

    always_comb begin
        sel = '0;
        if (hold_q) begin
            sel = hold_gnt_q;
        end else if (vld == 2'b01) begin
            sel = 2'b01;
        end else if (vld == 2'b10) begin
            sel = 2'b10;
        end else if (vld == 2'b11) begin
`ifdef ALU_ARB_AGE_PRIO_EN
            sel = age_pick_lane1(buf_req[0].cid, buf_req[1].cid) ? 2'b10 : 2'b01;
`else
            sel = rr_q ? 2'b10 : 2'b01;
`endif
        end
    end

    // Flush blanks the presentation, so nothing can issue in a flush cycle.
    assign grant   = flush_i ? '0 : sel;
    assign issue   = grant & {NUM_LANES{~alu_stall_i}};
    assign sel_req = grant[1] ? buf_req[1] : (grant[0] ? buf_req[0] : '0);

    assign hold_d     = (|grant) & alu_stall_i;
    assign hold_gnt_d = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= 1'b0;
            hold_gnt_q <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_gnt_q <= hold_gnt_d;
        end
    end

`ifndef ALU_ARB_AGE_PRIO_EN
    // Pointer only moves on contention, and then away from the lane just served.
    always_comb begin
        rr_d = rr_q;
        if ((&vld) && (|issue)) begin
            rr_d = issue[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign req0_ready_o  = ready[0];
    assign req1_ready_o  = ready[1];
    assign req_alu_o     = |grant;
    assign grant_o       = grant;
    assign alu_op1_o     = sel_req.op1;
    assign alu_op2_o     = sel_req.op2;
    assign alu_op_info_o = sel_req.op_info;
    assign alu_rd_o      = sel_req.rd;
    assign alu_reg_we_o  = sel_req.reg_we;
    assign alu_cid_o     = sel_req.cid;

endmodule
